// File: rtl/zephyr_ram_arbiter.sv
// Two-port round-robin / fixed-priority arbiter in front of the 16x8 zephyr RAM.
// Each access takes IDLE -> ISSUE (RAM strobe) -> RESP (ack + read data).
module zephyr_ram_arbiter #(
    parameter int AW         = 4,
    parameter int DW         = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    // Handshake: req is a level held until ack; we/addr/wdata are stable
    // while req is high. ack is a one-cycle pulse, rdata is valid with ack
    // and held afterwards. A req still high in the IDLE after ack is new.
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          owner,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          lat_we_q, lat_we_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          grant1;
    logic          rd_live;

    // Port 1 wins when alone, or on a round-robin tie when port 0 went last.
    assign grant1 = req1 && (!req0 || (!FIXED_PRIO && !last_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        lat_we_d    = lat_we_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rd0_d       = rd0_q;
        rd1_d       = rd1_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d     = S_ISSUE;
                    owner_d     = grant1;
                    lat_we_d    = grant1 ? we1 : we0;
                    ram_en_d    = 1'b1;
                    ram_we_d    = grant1 ? we1 : we0;
                    ram_addr_d  = grant1 ? addr1 : addr0;
                    ram_wdata_d = grant1 ? wdata1 : wdata0;
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
                ack0_d  = !owner_q;
                ack1_d  = owner_q;
            end
            S_RESP: begin
                state_d = S_IDLE;
                last_d  = owner_q;
                if (!lat_we_q) begin
                    if (owner_q) rd1_d = ram_rdata;
                    else         rd0_d = ram_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            lat_we_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd0_q       <= '0;
            rd1_q       <= '0;
        end else begin
            last_q      <= last_d;
            owner_q     <= owner_d;
            lat_we_q    <= lat_we_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
        end
    end

    // The RAM's registered read lands during RESP, so the owner's rdata is
    // bypassed from the RAM in that cycle to be valid alongside ack.
    assign rd_live = (state_q == S_RESP) && !lat_we_q;

    assign rdata0    = (rd_live && !owner_q) ? ram_rdata : rd0_q;
    assign rdata1    = (rd_live &&  owner_q) ? ram_rdata : rd1_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_zephyr_ram_arbiter.sv
// Directed bench for zephyr_ram_arbiter: vector table of single-port accesses
// plus hand sequences for reset, round-robin, fixed priority and back-to-back.
module tb_zephyr_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, ram_en, ram_we, busy, owner;
    logic [7:0] rdata0, rdata1, ram_wdata, ram_rdata;
    logic [3:0] ram_addr;
    logic [1:0] state_dbg;

    logic       req0_f, we0_f, req1_f, we1_f;
    logic [3:0] addr0_f, addr1_f;
    logic [7:0] wdata0_f, wdata1_f;
    logic       ack0_f, ack1_f, ram_en_f, ram_we_f, busy_f, owner_f;
    logic [7:0] rdata0_f, rdata1_f, ram_wdata_f, ram_rdata_f;
    logic [3:0] ram_addr_f;
    logic [1:0] state_dbg_f;

    logic [7:0] mem   [16];
    logic [7:0] mem_f [16];

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_rd0, exp_rd1;
    logic [1:0] exp_q[$];

    typedef struct {
        logic       p;
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    zephyr_ram_arbiter #(.AW(4), .DW(8), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner), .state_dbg(state_dbg)
    );

    zephyr_ram_arbiter #(.AW(4), .DW(8), .FIXED_PRIO(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_f), .we0(we0_f), .addr0(addr0_f), .wdata0(wdata0_f), .ack0(ack0_f), .rdata0(rdata0_f),
        .req1(req1_f), .we1(we1_f), .addr1(addr1_f), .wdata1(wdata1_f), .ack1(ack1_f), .rdata1(rdata1_f),
        .ram_en(ram_en_f), .ram_we(ram_we_f), .ram_addr(ram_addr_f), .ram_wdata(ram_wdata_f),
        .ram_rdata(ram_rdata_f), .busy(busy_f), .owner(owner_f), .state_dbg(state_dbg_f)
    );

    // Synchronous-read RAM models, not reset by rst_n
    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]   = 8'h00;
            mem_f[i] = 8'h00;
        end
        ram_rdata   = 8'h00;
        ram_rdata_f = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
        if (ram_en_f) begin
            if (ram_we_f) mem_f[ram_addr_f] <= ram_wdata_f;
            else          ram_rdata_f       <= mem_f[ram_addr_f];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single access from IDLE; entered and left on a falling edge.
    task automatic do_access(input logic p, input logic we, input logic [3:0] a,
                             input logic [7:0] wd, input logic [7:0] rd);
        if (!p) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        tick();
        chk("issue_ram_en", ram_en, 1);
        chk("issue_ram_we", ram_we, we);
        chk("issue_ram_addr", ram_addr, a);
        if (we) chk("issue_ram_wdata", ram_wdata, wd);
        chk("issue_owner", owner, p);
        chk("issue_busy", busy, 1);
        chk("issue_no_ack", ack0 | ack1, 0);
        tick();
        if (!we) begin
            if (!p) exp_rd0 = rd;
            else    exp_rd1 = rd;
        end
        chk("resp_ack_owner", p ? ack1 : ack0, 1);
        chk("resp_ack_other", p ? ack0 : ack1, 0);
        chk("resp_ram_en", ram_en, 0);
        chk("resp_rdata0", rdata0, exp_rd0);
        chk("resp_rdata1", rdata1, exp_rd1);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk("idle_ack", ack0 | ack1, 0);
        chk("idle_busy", busy, 0);
        chk("hold_rdata0", rdata0, exp_rd0);
        chk("hold_rdata1", rdata1, exp_rd1);
    endtask

    initial begin
        int n0, n1, last_c;
        logic got;

        vecs[0] = '{1'b1, 1'b1, 4'd14, 8'hFA, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 4'd14, 8'h00, 8'hFA};
        vecs[2] = '{1'b0, 1'b1, 4'd15, 8'hFF, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 4'd15, 8'h00, 8'hFF};
        vecs[4] = '{1'b0, 1'b1, 4'd3,  8'h21, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 4'd3,  8'h00, 8'h21};
        vecs[6] = '{1'b1, 1'b1, 4'd0,  8'h3C, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 4'd0,  8'h00, 8'h3C};
        vecs[8] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'hFF};

        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 4'd0; wdata1 = 8'h00;
        req0_f = 1'b0; we0_f = 1'b0; addr0_f = 4'd1; wdata0_f = 8'h00;
        req1_f = 1'b0; we1_f = 1'b0; addr1_f = 4'd2; wdata1_f = 8'h00;
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;

        // Reset held with a pending request
        repeat (3) @(negedge clk);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_ram_en", ram_en, 1);
        tick();
        chk("rel_ack0", ack0, 1);
        chk("rel_rdata0", rdata0, 8'h00);
        req0 = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            do_access(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].rd);

        // Round-robin: both ports hold req; port 1 went last so port 0 leads
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd15;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd14;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        n0 = 0;
        last_c = -1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk("rr_ack_exclusive", ack0 & ack1, 0);
            if (ack0 || ack1) begin
                n0++;
                if (exp_q.size() > 0) chk("rr_order", {1'b0, ack1}, exp_q.pop_front());
                if (last_c >= 0) chk("rr_spacing", c - last_c, 3);
                last_c = c;
                if (ack0) chk("rr_rdata0", rdata0, 8'hFF);
                else      chk("rr_rdata1", rdata1, 8'hFA);
            end
        end
        chk("rr_ack_count", n0, 4);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();

        // Fixed priority instance: port 0 re-requests forever, port 1 starves
        req0_f = 1'b1;
        req1_f = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (ack0_f) n0++;
            if (ack1_f) n1++;
        end
        chk("fp_port0_acks", n0, 4);
        chk("fp_port1_starved", n1, 0);
        req0_f = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (ack1_f) got = 1'b1;
            chk("fp_no_ack0_after_drop", ack0_f, 0);
        end
        chk("fp_port1_ack_within_3", got, 1);
        req1_f = 1'b0;
        tick();

        // Back-to-back on port 0, second request withdrawn during ISSUE
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 8'h5A;
        tick();
        chk("b2b_issue1", ram_en, 1);
        tick();
        chk("b2b_ack1", ack0, 1);
        we0 = 1'b0;
        tick();
        chk("b2b_gap_ram_en", ram_en, 0);
        chk("b2b_gap_state", state_dbg, 0);
        tick();
        chk("b2b_issue2_en", ram_en, 1);
        chk("b2b_issue2_we", ram_we, 0);
        chk("b2b_issue2_addr", ram_addr, 5);
        req0 = 1'b0;
        tick();
        chk("b2b_ack2", ack0, 1);
        chk("b2b_rdata0", rdata0, 8'h5A);
        exp_rd0 = 8'h5A;
        tick();
        chk("b2b_done_ack", ack0, 0);
        chk("b2b_done_en", ram_en, 0);
        chk("b2b_addr_hold", ram_addr, 5);

        // Reset during the ISSUE cycle of a write of 55 to addr 3
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'h55;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ram_en", ram_en, 0);
        chk("abort_busy", busy, 0);
        req0 = 1'b0;
        @(negedge clk);
        tick();
        chk("abort_no_ack0", ack0, 0);
        chk("abort_mem3", mem[3], 8'h21);
        rst_n = 1'b1;
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;
        chk("abort_rdata0_reset", rdata0, 8'h00);
        tick();
        do_access(1'b0, 1'b0, 4'd3, 8'h00, 8'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
